// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types, defaults and address helper for the pixel sink.
package pixel_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
    localparam int ENTRY_W = 9 + 9 + 3;
    localparam int DEF_RES_X = 160;
    localparam int DEF_RES_Y = 120;
    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] color;
    } pixel_t;
    function automatic logic [31:0] lin_addr(input logic [8:0] x, input logic [8:0] y, input int res_x);
        return 32'(y) * 32'(res_x) + 32'(x);
    endfunction
endpackage

// File: rtl/pixel_sink_if.sv
// pixel_sink_if: plot/x/y/color handshake between sprite datapath and pixel sink.
interface pixel_sink_if;
    logic       plot;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] color;
    logic       ready;
    modport master (output plot, x, y, color, input ready);
    modport slave (input plot, x, y, color, output ready);
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO, power-of-two depth, async active-low reset.
module pixel_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/pixel_sink.sv
// pixel_sink: buffers plotted pixels, range-checks them and writes the framebuffer;
// also runs a full-screen clear sweep while new pixels keep buffering.
module pixel_sink
    import pixel_pkg::*;
#(
    parameter int         RES_X       = DEF_RES_X,
    parameter int         RES_Y       = DEF_RES_Y,
    parameter int         ADDR_WIDTH  = 15,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_sink_if.slave           pix,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_data,
    output logic [7:0]            dropped
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RES_X * RES_Y - 1);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [2:0] data_q, data_d;
    logic [7:0] drop_q, drop_d;
    logic we_q, we_d;
    logic full, empty, in_range, accept, push, pop;
    logic [CW-1:0] count;
    logic [ENTRY_W-1:0] head;
    pixel_t head_pix;
    assign in_range  = 32'(pix.x) < 32'(RES_X) && 32'(pix.y) < 32'(RES_Y);
    assign pix.ready = count != CW'(FIFO_DEPTH);
    assign accept    = pix.plot && !full;
    assign push      = accept && in_range;
    assign pop       = state_q == S_IDLE && !empty;
    assign head_pix  = pixel_t'(head);
    pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({pix.x, pix.y, pix.color}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        drop_d  = (accept && !in_range && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
        if (state_q == S_IDLE) begin
            we_d    = pop;
            addr_d  = pop ? ADDR_WIDTH'(lin_addr(head_pix.x, head_pix.y, RES_X)) : addr_q;
            data_d  = pop ? head_pix.color : data_q;
            state_d = clear_req ? S_CLEAR : S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_CLEAR) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            data_d  = CLEAR_COLOR;
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            state_d = cnt_q == LAST ? S_DONE : S_CLEAR;
        end else begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end
    // S_DONE coincides with the cycle the last clear write is presented
    assign clear_busy = state_q != S_IDLE;
    assign clear_done = state_q == S_DONE;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign dropped    = drop_q;
endmodule

// File: tb/tb_pixel_sink.sv
// tb_pixel_sink: table-driven plots, scoreboard of expected framebuffer writes, clear corner cases.
module tb_pixel_sink;
    localparam int NPIX = 160 * 120;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear_req = 1'b0;
    logic clear_busy, clear_done, mem_we;
    logic [14:0] mem_addr;
    logic [2:0] mem_data;
    logic [7:0] dropped;
    pixel_sink_if pif ();
    pixel_sink dut (
        .clk        (clk),
        .reset      (reset),
        .pix        (pif),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .dropped    (dropped)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [14:0] addr;
        logic [2:0]  data;
    } wr_t;
    typedef struct {
        int x;
        int y;
        int c;
        int addr;
    } vec_t;
    wr_t sb[$];
    vec_t tbl[8];
    int n_chk = 0, n_fail = 0;
    int busy_cnt = 0, done_cnt = 0, post_done_wr = 0, pend_px = 0, exp_dropped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                chk("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_data", 32'(mem_data), 32'(e.data));
                end
                post_done_wr++;
            end
            if (clear_busy) busy_cnt++;
            if (clear_done) begin
                done_cnt++;
                chk("done_align", 32'(sb.size()), 32'(pend_px));
                post_done_wr = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plot1(input int px, input int py, input int pc);
        pif.plot  = 1'b1;
        pif.x     = 9'(px);
        pif.y     = 9'(py);
        pif.color = 3'(pc);
        step();
        pif.plot = 1'b0;
    endtask

    task automatic start_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < NPIX; i++) sb.push_back('{15'(i), 3'b000});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 25000 && done_cnt < target; i++) step();
        chk("done_seen", 32'(done_cnt), 32'(target));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(pif.ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_busy"}, 32'(clear_busy), 32'd0);
        chk({tag, "_done"}, 32'(clear_done), 32'd0);
        chk({tag, "_dropped"}, 32'(dropped), 32'd0);
    endtask

    initial begin
        int d0;
        tbl[0] = '{0, 0, 7, 0};
        tbl[1] = '{159, 119, 1, 19199};
        tbl[2] = '{160, 0, 2, -1};
        tbl[3] = '{0, 120, 3, -1};
        tbl[4] = '{159, 0, 2, 159};
        tbl[5] = '{0, 119, 3, 19040};
        tbl[6] = '{511, 511, 6, -1};
        tbl[7] = '{10, 10, 4, 1610};
        pif.plot = 1'b0;
        pif.x = '0;
        pif.y = '0;
        pif.color = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;
        step();
        sb.push_back('{15'd323, 3'd5});
        plot1(3, 2, 5);
        @(negedge clk) chk("lat_edgeN", 32'(mem_we), 32'd0);
        @(negedge clk) begin
            chk("lat_edgeN1", 32'(mem_we), 32'd1);
            chk("first_addr", 32'(mem_addr), 32'd323);
        end
        step();
        step();
        chk("first_dropped", 32'(dropped), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].addr >= 0) sb.push_back('{15'(tbl[i].addr), 3'(tbl[i].c)});
            else exp_dropped++;
            plot1(tbl[i].x, tbl[i].y, tbl[i].c);
            repeat (3) step();
            chk("vec_dropped", 32'(dropped), 32'(exp_dropped));
            chk("vec_drained", 32'(sb.size()), 32'd0);
        end
        pif.plot = 1'b1;
        pif.x = 9'd200;
        pif.y = 9'd0;
        repeat (300) step();
        pif.plot = 1'b0;
        step();
        chk("dropped_sat", 32'(dropped), 32'd255);
        // clear with 3 pixels pushed during the sweep
        busy_cnt = 0;
        d0 = done_cnt;
        pend_px = 3;
        start_clear();
        sb.push_back('{15'd1, 3'd6});
        plot1(1, 0, 6);
        sb.push_back('{15'd165, 3'd3});
        plot1(5, 1, 3);
        sb.push_back('{15'd19199, 3'd7});
        plot1(159, 119, 7);
        wait_done(d0 + 1);
        repeat (6) step();
        chk("clrA_drained", 32'(sb.size()), 32'd0);
        chk("clrA_busy_cycles", 32'(busy_cnt), 32'(NPIX + 1));
        chk("clrA_done_pulses", 32'(done_cnt), 32'(d0 + 1));
        chk("clrA_post_writes", 32'(post_done_wr), 32'd3);
        // 12 back-to-back pushes during a clear, plus a second clear_req mid-sweep
        busy_cnt = 0;
        d0 = done_cnt;
        pend_px = 8;
        start_clear();
        for (int i = 0; i < 12; i++) begin
            pif.plot = 1'b1;
            pif.x = 9'(i);
            pif.y = 9'd1;
            pif.color = 3'(i);
            @(negedge clk) chk("fill_ready", 32'(pif.ready), 32'(i < 8));
            if (i < 8) sb.push_back('{15'(160 + i), 3'(i)});
            step();
        end
        pif.plot = 1'b0;
        chk("full_ready_low", 32'(pif.ready), 32'd0);
        repeat (1000) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_done(d0 + 1);
        repeat (20) step();
        chk("clrB_drained", 32'(sb.size()), 32'd0);
        chk("clrB_busy_cycles", 32'(busy_cnt), 32'(NPIX + 1));
        chk("clrB_done_pulses", 32'(done_cnt), 32'(d0 + 1));
        chk("clrB_post_writes", 32'(post_done_wr), 32'd8);
        // reset in the middle of a sweep
        d0 = done_cnt;
        start_clear();
        repeat (5000) step();
        chk("mid_busy", 32'(clear_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        sb.delete();
        exp_dropped = 0;
        repeat (3) step();
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        reset = 1'b1;
        step();
        sb.push_back('{15'd487, 3'd2});
        plot1(7, 3, 2);
        repeat (4) step();
        chk("post_rst_drained", 32'(sb.size()), 32'd0);
        chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
        chk("post_rst_dropped", 32'(dropped), 32'(exp_dropped));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
